// File: rtl/fft_tw_sched.sv
// Radix-2 DIT FFT butterfly scheduler: walks every stage of an N-point
// transform, issuing (addr_a, addr_b, tw_idx) commands with a drain gap per stage.
module fft_tw_sched #(
  parameter int LOG2N    = 7,
  parameter int PIPE_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             bf_ready,
  output logic             bf_valid,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-1:0] tw_idx,
  output logic [2:0]       stage,
  output logic             busy,
  output logic             done
);

  localparam int               J_W        = LOG2N - 1;
  localparam logic [J_W-1:0]   J_LAST     = '1;
  localparam logic [J_W-1:0]   J_ONE      = J_W'(1);
  localparam logic [2:0]       S_LAST     = 3'(LOG2N - 1);
  localparam logic [3:0]       DRAIN_LAST = 4'(PIPE_LAT - 1);
  localparam logic [LOG2N-1:0] A_ONE      = LOG2N'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [J_W-1:0]   j_q, j_d;
  logic [2:0]       s_q, s_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             bf_valid_q, bf_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2:0]       stage_q, stage_d;
  logic [LOG2N-1:0] addr_a_q, addr_a_d;
  logic [LOG2N-1:0] addr_b_q, addr_b_d;
  logic [LOG2N-1:0] tw_idx_q, tw_idx_d;

  function automatic logic [LOG2N-1:0] span_of(input logic [2:0] s);
    return A_ONE << s;
  endfunction

  function automatic logic [LOG2N-1:0] pos_of(input logic [J_W-1:0] j, input logic [2:0] s);
    logic [LOG2N-1:0] jx;
    jx = {1'b0, j};
    return jx & (span_of(s) - A_ONE);
  endfunction

  // Butterflies of one group sit span apart; groups are 2*span wide.
  function automatic logic [LOG2N-1:0] upper_addr(input logic [J_W-1:0] j, input logic [2:0] s);
    logic [LOG2N-1:0] jx;
    logic [LOG2N-1:0] grp;
    jx  = {1'b0, j};
    grp = jx >> s;
    return (grp << (s + 3'd1)) | pos_of(j, s);
  endfunction

  function automatic logic [LOG2N-1:0] twiddle(input logic [J_W-1:0] j, input logic [2:0] s);
    return pos_of(j, s) << (S_LAST - s);
  endfunction

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    s_d     = s_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          j_d     = '0;
          s_d     = '0;
        end
      end
      RUN: begin
        if (bf_ready) begin
          if (j_q == J_LAST) begin
            j_d     = '0;
            cnt_d   = DRAIN_LAST;
            state_d = DRAIN;
          end else begin
            j_d = j_q + J_ONE;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == 4'd0) begin
          if (s_q == S_LAST) begin
            state_d = DONE;
          end else begin
            s_d     = s_q + 3'd1;
            state_d = RUN;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        s_d     = '0;
      end
      default: state_d = IDLE;
    endcase

    // Abort beats any handshake landing on the same edge.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      j_d     = '0;
      s_d     = '0;
      cnt_d   = '0;
    end
  end

  // Outputs are precomputed from the next state so they leave the flops directly.
  always_comb begin
    bf_valid_d = (state_d == RUN);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    stage_d    = busy_d ? s_d : 3'd0;
    addr_a_d   = '0;
    addr_b_d   = '0;
    tw_idx_d   = '0;
    if (state_d == RUN) begin
      addr_a_d = upper_addr(j_d, s_d);
      addr_b_d = addr_a_d + span_of(s_d);
      tw_idx_d = twiddle(j_d, s_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      j_q        <= '0;
      s_q        <= '0;
      cnt_q      <= '0;
      bf_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      stage_q    <= '0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      tw_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      j_q        <= j_d;
      s_q        <= s_d;
      cnt_q      <= cnt_d;
      bf_valid_q <= bf_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      stage_q    <= stage_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      tw_idx_q   <= tw_idx_d;
    end
  end

  assign bf_valid = bf_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign stage    = stage_q;
  assign addr_a   = addr_a_q;
  assign addr_b   = addr_b_q;
  assign tw_idx   = tw_idx_q;

endmodule

// File: tb/tb_fft_tw_sched.sv
// Scoreboard bench for fft_tw_sched: a 128-point instance for the main scenarios
// and an 8-point instance for the small-size case.
module tb_fft_tw_sched;

  localparam int N = 128;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0, abort = 1'b0, bf_ready = 1'b0;
  logic       bf_valid, busy, done;
  logic [6:0] addr_a, addr_b, tw_idx;
  logic [2:0] stage;

  logic       start3 = 1'b0, abort3 = 1'b0, ready3 = 1'b0;
  logic       valid3, busy3, done3;
  logic [2:0] a3, b3, tw3, stage3;

  always #5 clk = ~clk;

  fft_tw_sched #(.LOG2N(7), .PIPE_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bf_ready(bf_ready),
    .bf_valid(bf_valid), .addr_a(addr_a), .addr_b(addr_b), .tw_idx(tw_idx),
    .stage(stage), .busy(busy), .done(done)
  );

  fft_tw_sched #(.LOG2N(3), .PIPE_LAT(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .bf_ready(ready3),
    .bf_valid(valid3), .addr_a(a3), .addr_b(b3), .tw_idx(tw3),
    .stage(stage3), .busy(busy3), .done(done3)
  );

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [23:0] exp_q[$];
  int          rec_busy, rec_hs, rec_done;
  logic [23:0] rec_first, rec_s3j13, rec_s6j5;

  // Expected command stream built by walking groups and positions directly.
  task automatic fill_queue();
    int span, a;
    exp_q.delete();
    for (int s = 0; s < 7; s++) begin
      span = 1 << s;
      for (int g = 0; g < N / (2 * span); g++) begin
        for (int p = 0; p < span; p++) begin
          a = g * 2 * span + p;
          exp_q.push_back({3'(s), 7'(a), 7'(a + span), 7'(p * (N / (2 * span)))});
        end
      end
    end
  endtask

  task automatic drive_pass(input bit throttle, input bit hold_start);
    int          guard;
    int          jcnt[8];
    logic [23:0] cmd;
    fill_queue();
    rec_busy = 0; rec_hs = 0; rec_done = 0;
    rec_first = '1; rec_s3j13 = '1; rec_s6j5 = '1;
    for (int i = 0; i < 8; i++) jcnt[i] = 0;
    start = 1'b1;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    guard = 0;
    while (busy === 1'b1 && guard < 4000) begin
      rec_busy++;
      if (done === 1'b1) rec_done++;
      bf_ready = throttle ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (bf_valid === 1'b1) begin
        cmd = {stage, addr_a, addr_b, tw_idx};
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_extra got %h required none", cmd);
        end else if (cmd !== exp_q[0]) begin
          tests_failed++;
          $display("FAIL sb_cmd got %h required %h", cmd, exp_q[0]);
        end
        if (bf_ready) begin
          if (rec_hs == 0) rec_first = cmd;
          if (stage == 3'd3 && jcnt[3] == 13) rec_s3j13 = cmd;
          if (stage == 3'd6 && jcnt[6] == 5) rec_s6j5 = cmd;
          jcnt[stage]++;
          rec_hs++;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    bf_ready = 1'b0;
    tests_run++;
    if (guard >= 4000) begin
      tests_failed++;
      $display("FAIL pass_timeout got %0d cycles required < 4000", guard);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bf_valid, busy, done, stage, addr_a, addr_b, tw_idx} !== 27'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got %h required 0",
               {bf_valid, busy, done, stage, addr_a, addr_b, tw_idx});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || valid3 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle got busy=%b valid3=%b required 0", busy, valid3);
    end
  endtask

  task automatic test_basic();
    drive_pass(1'b0, 1'b0);
    tests_run++;
    if (rec_first !== {3'd0, 7'd0, 7'd1, 7'd0}) begin
      tests_failed++; $display("FAIL first_cmd got %h required %h", rec_first, {3'd0, 7'd0, 7'd1, 7'd0});
    end
    tests_run++;
    if (rec_hs !== 448) begin
      tests_failed++; $display("FAIL hs_count got %0d required 448", rec_hs);
    end
    tests_run++;
    if (rec_busy !== 477) begin
      tests_failed++; $display("FAIL busy_cycles got %0d required 477", rec_busy);
    end
    tests_run++;
    if (rec_done !== 1) begin
      tests_failed++; $display("FAIL done_pulses got %0d required 1", rec_done);
    end
    tests_run++;
    if (rec_s3j13 !== {3'd3, 7'd21, 7'd29, 7'd40}) begin
      tests_failed++; $display("FAIL s3_j13 got %h required %h", rec_s3j13, {3'd3, 7'd21, 7'd29, 7'd40});
    end
    tests_run++;
    if (rec_s6j5 !== {3'd6, 7'd5, 7'd69, 7'd5}) begin
      tests_failed++; $display("FAIL s6_j5 got %h required %h", rec_s6j5, {3'd6, 7'd5, 7'd69, 7'd5});
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++; $display("FAIL sb_leftover got %0d required 0", exp_q.size());
    end
  endtask

  task automatic test_throttle();
    drive_pass(1'b1, 1'b0);
    tests_run++;
    if (rec_hs !== 448 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL throttle_count got %0d left %0d required 448 left 0", rec_hs, exp_q.size());
    end
    tests_run++;
    if (rec_done !== 1) begin
      tests_failed++; $display("FAIL throttle_done got %0d required 1", rec_done);
    end
  endtask

  task automatic test_start_ignored();
    drive_pass(1'b0, 1'b1);
    tests_run++;
    if (rec_busy !== 477 || rec_hs !== 448) begin
      tests_failed++;
      $display("FAIL start_held got busy=%0d hs=%0d required 477/448", rec_busy, rec_hs);
    end
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL start_in_done got busy=%b required 0", busy);
    end
  endtask

  task automatic test_abort();
    int guard;
    int dones;
    start = 1'b1; bf_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(stage == 3'd2 && bf_valid === 1'b1) && guard < 2000) begin
      @(negedge clk); guard++;
    end
    repeat (10) @(negedge clk);
    tests_run++;
    if (guard >= 2000 || bf_valid !== 1'b1) begin
      tests_failed++; $display("FAIL abort_reach_stage2 got stage=%0d valid=%b required 2/1", stage, bf_valid);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    bf_ready = 1'b0;
    tests_run++;
    if ({busy, bf_valid, done, stage} !== 6'd0) begin
      tests_failed++;
      $display("FAIL abort_idle got busy=%b valid=%b done=%b stage=%0d required 0", busy, bf_valid, done, stage);
    end
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) dones++;
    end
    tests_run++;
    if (dones != 0) begin
      tests_failed++; $display("FAIL abort_no_done got %0d active cycles required 0", dones);
    end
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || bf_valid !== 1'b1 || stage !== 3'd0) begin
      tests_failed++; $display("FAIL abort_in_idle got busy=%b valid=%b required 1/1", busy, bf_valid);
    end
    @(negedge clk);
    abort = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL abort_in_run got busy=%b required 0", busy);
    end
    drive_pass(1'b0, 1'b0);
    tests_run++;
    if (rec_first !== 24'd128 || rec_hs !== 448 || rec_done !== 1) begin
      tests_failed++;
      $display("FAIL abort_restart got first=%h hs=%0d done=%0d required 000080/448/1", rec_first, rec_hs, rec_done);
    end
  endtask

  task automatic test_reset_drain();
    int guard;
    start = 1'b1; bf_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(stage == 3'd2 && busy === 1'b1 && bf_valid === 1'b0) && guard < 2000) begin
      @(negedge clk); guard++;
    end
    tests_run++;
    if (guard >= 2000) begin
      tests_failed++; $display("FAIL drain_reach got stage=%0d busy=%b required 2/1", stage, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bf_valid, busy, done, stage, addr_a, addr_b, tw_idx} !== 27'd0) begin
      tests_failed++;
      $display("FAIL reset_drain got %h required 0", {bf_valid, busy, done, stage, addr_a, addr_b, tw_idx});
    end
    @(negedge clk);
    rst_n = 1'b1;
    bf_ready = 1'b0;
    guard = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b0 || bf_valid !== 1'b0) guard++;
    end
    tests_run++;
    if (guard != 0) begin
      tests_failed++; $display("FAIL reset_wait got %0d active cycles required 0", guard);
    end
  endtask

  task automatic test_small();
    int guard, hs, bcyc, dones, nseq;
    int seq[4];
    int exp_tw[4];
    exp_tw = '{0, 1, 2, 3};
    for (int i = 0; i < 4; i++) seq[i] = -1;
    hs = 0; bcyc = 0; dones = 0; nseq = 0; guard = 0;
    start3 = 1'b1; ready3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    while (busy3 === 1'b1 && guard < 200) begin
      bcyc++;
      if (done3 === 1'b1) dones++;
      if (valid3 === 1'b1) begin
        hs++;
        if (stage3 == 3'd2 && nseq < 4) begin
          seq[nseq] = int'(tw3);
          nseq++;
        end
      end
      @(negedge clk); guard++;
    end
    ready3 = 1'b0;
    tests_run++;
    if (hs != 12) begin
      tests_failed++; $display("FAIL small_hs got %0d required 12", hs);
    end
    tests_run++;
    if (bcyc != 25) begin
      tests_failed++; $display("FAIL small_busy got %0d required 25", bcyc);
    end
    tests_run++;
    if (dones != 1) begin
      tests_failed++; $display("FAIL small_done got %0d required 1", dones);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (seq[i] != exp_tw[i]) begin
        tests_failed++; $display("FAIL small_tw%0d got %0d required %0d", i, seq[i], exp_tw[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_throttle();
    test_start_ignored();
    test_abort();
    test_reset_drain();
    test_small();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
